// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Iteration counter width: enough bits to hold WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/addsub_nbit.sv
// Combinational WIDTH+1-bit adder/subtractor for the partial-product step.
module addsub_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub_en,
  output logic [WIDTH:0] sum
);

  assign sum = sub_en ? (a - b) : (a + b);

endmodule

// File: rtl/multiplier_n.sv
// Sequential shift-add multiplier with signed/unsigned modes and a
// start/busy/done handshake; product is {A, B} after 2*WIDTH cycles.
module multiplier_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Signed_mode,
  input  logic [WIDTH-1:0]   Mcand,
  input  logic [WIDTH-1:0]   Mplier,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product,
  output logic [WIDTH-1:0]   Aval,
  output logic [WIDTH-1:0]   Bval,
  output logic               X
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, m_reg;
  logic             x_reg, mode;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   add_a, add_b, add_sum;
  logic             sub_en;

  // Handshake: Start is a level sampled only in IDLE; Done stays up while
  // Start is held so a held button yields one operation, not repeats.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = ADD;
      ADD:     state_next = SHIFT;
      SHIFT:   state_next = (count == LAST) ? DONE : ADD;
      DONE:    if (!Start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign- or zero-extend both addends; in signed mode the final bit of the
  // multiplier carries negative weight, so that step subtracts M.
  always_comb begin
    add_a  = {mode & a_reg[WIDTH-1], a_reg};
    add_b  = {mode & m_reg[WIDTH-1], m_reg};
    sub_en = mode && (count == LAST);
  end

  addsub_nbit #(.WIDTH(WIDTH)) u_addsub (
    .a      (add_a),
    .b      (add_b),
    .sub_en (sub_en),
    .sum    (add_sum)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_reg <= '0;
      b_reg <= '0;
      m_reg <= '0;
      x_reg <= 1'b0;
      mode  <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_reg <= '0;
            x_reg <= 1'b0;
            b_reg <= Mplier;
            m_reg <= Mcand;
            mode  <= Signed_mode;
            count <= '0;
          end
        end
        ADD: begin
          if (b_reg[0]) {x_reg, a_reg} <= add_sum;
          else          x_reg <= mode & a_reg[WIDTH-1];
        end
        SHIFT: begin
          a_reg <= {x_reg, a_reg[WIDTH-1:1]};
          b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
          x_reg <= mode & x_reg;
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy    = (state == ADD) || (state == SHIFT);
  assign Done    = (state == DONE);
  assign Aval    = a_reg;
  assign Bval    = b_reg;
  assign X       = x_reg;
  assign Product = {a_reg, b_reg};

endmodule

// File: tb/tb_multiplier_n.sv
// Directed-vector bench for multiplier_n at WIDTH=8 and WIDTH=4.
module tb_multiplier_n;

  logic clk;
  logic rst;

  logic        start8, sm8;
  logic [7:0]  mcand8, mplier8;
  logic        busy8, done8, x8;
  logic [15:0] prod8;
  logic [7:0]  aval8, bval8;

  logic        start4, sm4;
  logic [3:0]  mcand4, mplier4;
  logic        busy4, done4, x4;
  logic [7:0]  prod4;
  logic [3:0]  aval4, bval4;

  int checks;
  int failures;

  multiplier_n #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset(rst), .Start(start8), .Signed_mode(sm8),
    .Mcand(mcand8), .Mplier(mplier8), .Busy(busy8), .Done(done8),
    .Product(prod8), .Aval(aval8), .Bval(bval8), .X(x8)
  );

  multiplier_n #(.WIDTH(4)) u_dut4 (
    .Clk(clk), .Reset(rst), .Start(start4), .Signed_mode(sm4),
    .Mcand(mcand4), .Mplier(mplier4), .Busy(busy4), .Done(done4),
    .Product(prod4), .Aval(aval4), .Bval(bval4), .X(x4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one-cycle Start pulse, then wait (bounded) for Done.
  // lat counts edges after the Start edge; bc counts Busy-high samples.
  task automatic run8(input logic mode, input logic [7:0] mc, input logic [7:0] mp,
                      output logic [15:0] prod, output logic x, output int lat, output int bc);
    sm8 = mode; mcand8 = mc; mplier8 = mp; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0; bc = 0;
    if (busy8) bc++;
    while (!done8 && lat < 200) begin
      tick();
      lat++;
      if (busy8) bc++;
    end
    prod = prod8;
    x    = x8;
  endtask

  task automatic run4(input logic mode, input logic [3:0] mc, input logic [3:0] mp,
                      output logic [7:0] prod, output int lat);
    sm4 = mode; mcand4 = mc; mplier4 = mp; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 200) begin
      tick();
      lat++;
    end
    prod = prod4;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (prod8 !== 16'h0000) begin failures++; $display("FAIL reset_prod8 got=%h exp=0000", prod8); end
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin failures++; $display("FAIL reset_hs8 busy=%b done=%b exp=0/0", busy8, done8); end
    checks++; if (x8 !== 1'b0) begin failures++; $display("FAIL reset_x8 got=%b exp=0", x8); end
    checks++; if (prod4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0) begin failures++; $display("FAIL reset_dut4 prod=%h busy=%b done=%b exp=00/0/0", prod4, busy4, done4); end
  endtask

  task automatic test_signed_basic();
    logic [15:0] p; logic x; int lat, bc;
    run8(1'b1, 8'h07, 8'hFD, p, x, lat, bc);
    checks++; if (lat !== 16) begin failures++; $display("FAIL s7x-3_latency got=%0d exp=16", lat); end
    checks++; if (bc !== 16) begin failures++; $display("FAIL s7x-3_busy_cycles got=%0d exp=16", bc); end
    checks++; if (p !== 16'hFFEB) begin failures++; $display("FAIL s7x-3_product got=%h exp=FFEB", p); end
    checks++; if (x !== 1'b1) begin failures++; $display("FAIL s7x-3_x got=%b exp=1", x); end
    tick();
    checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL s7x-3_single_done got=%b exp=0", done8); end
  endtask

  task automatic test_all_ones();
    logic [15:0] p; logic x; int lat, bc;
    run8(1'b0, 8'hFF, 8'hFF, p, x, lat, bc);
    checks++; if (p !== 16'hFE01) begin failures++; $display("FAIL uFFxFF_product got=%h exp=FE01", p); end
    checks++; if (x !== 1'b0) begin failures++; $display("FAIL uFFxFF_x got=%b exp=0", x); end
    tick();
    run8(1'b1, 8'hFF, 8'hFF, p, x, lat, bc);
    checks++; if (p !== 16'h0001) begin failures++; $display("FAIL sFFxFF_product got=%h exp=0001", p); end
    tick();
  endtask

  task automatic test_signed_corner();
    logic [15:0] p; logic x; int lat, bc;
    run8(1'b1, 8'h80, 8'h80, p, x, lat, bc);
    checks++; if (p !== 16'h4000) begin failures++; $display("FAIL s80x80_product got=%h exp=4000", p); end
    tick();
    run8(1'b1, 8'h05, 8'hFF, p, x, lat, bc);
    checks++; if (p !== 16'hFFFB) begin failures++; $display("FAIL s05xFF_product got=%h exp=FFFB", p); end
    tick();
  endtask

  task automatic test_start_held();
    int lat;
    sm8 = 1'b0; mcand8 = 8'h06; mplier8 = 8'h09; start8 = 1'b1;
    tick();
    lat = 0;
    while (!done8 && lat < 200) begin tick(); lat++; end
    checks++; if (lat !== 16) begin failures++; $display("FAIL held_latency got=%0d exp=16", lat); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (done8 !== 1'b1 || busy8 !== 1'b0) begin failures++; $display("FAIL held_done_stays cyc=%0d done=%b busy=%b exp=1/0", i, done8, busy8); end
    end
    checks++; if (prod8 !== 16'h0036) begin failures++; $display("FAIL held_product got=%h exp=0036", prod8); end
    start8 = 1'b0;
    tick();
    checks++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin failures++; $display("FAIL held_release done=%b busy=%b exp=0/0", done8, busy8); end
  endtask

  task automatic test_ignored_inputs();
    int lat;
    sm8 = 1'b0; mcand8 = 8'h0C; mplier8 = 8'h0B; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    tick(); tick(); lat = 2;
    start8 = 1'b1; mcand8 = 8'h55; mplier8 = 8'hAA; sm8 = 1'b1;
    tick(); lat++;
    start8 = 1'b0;
    while (!done8 && lat < 200) begin tick(); lat++; end
    checks++; if (lat !== 16) begin failures++; $display("FAIL ignore_latency got=%0d exp=16", lat); end
    checks++; if (prod8 !== 16'h0084) begin failures++; $display("FAIL ignore_product got=%h exp=0084", prod8); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [15:0] p; logic x; int lat, bc;
    sm8 = 1'b0; mcand8 = 8'h12; mplier8 = 8'h34; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy8); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000 || x8 !== 1'b0)
      begin failures++; $display("FAIL midrst_outputs busy=%b done=%b prod=%h x=%b exp=0/0/0000/0", busy8, done8, prod8, x8); end
    run8(1'b0, 8'h03, 8'h04, p, x, lat, bc);
    checks++; if (p !== 16'h000C || lat !== 16) begin failures++; $display("FAIL midrst_after prod=%h lat=%0d exp=000C/16", p, lat); end
    tick();
  endtask

  task automatic test_width4();
    logic [7:0] p; int lat;
    run4(1'b0, 4'hF, 4'hF, p, lat);
    checks++; if (p !== 8'hE1) begin failures++; $display("FAIL w4_uFxF_product got=%h exp=E1", p); end
    checks++; if (lat !== 8) begin failures++; $display("FAIL w4_latency got=%0d exp=8", lat); end
    tick();
    run4(1'b1, 4'h8, 4'h7, p, lat);
    checks++; if (p !== 8'hC8) begin failures++; $display("FAIL w4_s8x7_product got=%h exp=C8", p); end
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; mcand8 = '0; mplier8 = '0;
    start4 = 1'b0; sm4 = 1'b0; mcand4 = '0; mplier4 = '0;
    test_reset();
    test_signed_basic();
    test_all_ones();
    test_signed_corner();
    test_start_held();
    test_ignored_inputs();
    test_reset_mid();
    test_width4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
